// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: address width,
// default write-protection mask and packed-port slice helpers.
package regfile_pkg;

  // r14 and r15 are write-protected unless the instance overrides the mask.
  localparam logic [15:0] DEFAULT_PROT_MASK = 16'hC000;

  // Address width for a register count; a single register still needs one bit.
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low bit of read port p inside the packed rd_addr bus.
  function automatic int rd_addr_lsb(input int p, input int aw);
    return p * aw;
  endfunction

  // Low bit of read port p inside the packed rd_data bus.
  function automatic int rd_data_lsb(input int p, input int dw);
    return p * dw;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks which registers have an outstanding claim
// from decode and resolves claim/clear priority when they collide.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [NUM_REGS-1:0] prot_mask,
  output logic                claim_ok,
  output logic                wr_valid,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_wr_same;

  // Grant and next-scoreboard: a writeback to the claimed register frees it
  // in the same cycle, and the claim is applied after the clear so it wins.
  always_comb begin
    wr_valid   = wr_en && !prot_mask[wr_addr];
    w_wr_same  = wr_valid && (wr_addr == claim_addr);
    claim_ok   = claim_en && !prot_mask[claim_addr] &&
                 (!r_busy[claim_addr] || w_wr_same);
    w_busy_nxt = r_busy;
    if (wr_valid) begin
      w_busy_nxt[wr_addr] = 1'b0;
    end
    if (claim_ok) begin
      w_busy_nxt[claim_addr] = 1'b1;
    end
  end

  // Scoreboard register; reset drops every outstanding claim at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_scoreboarded.sv
// Multi-read-port register file with write scoreboard, optional same-cycle
// write bypass, per-register write protection and a registered debug port.
//
// Handshake: decode presents claim_en/claim_addr and the claim is taken at
// the rising edge only in a cycle where claim_ok is high; otherwise decode
// holds and retries. Writeback (wr_en) has no back-pressure and is always
// accepted; writes to protected registers are dropped and flagged on wr_err.
module regfile_scoreboarded
  import regfile_pkg::*;
#(
  parameter  int                  DATA_W    = 32,
  parameter  int                  NUM_REGS  = 16,
  parameter  int                  NUM_RD    = 2,
  parameter  logic [NUM_REGS-1:0] PROT_MASK = NUM_REGS'(DEFAULT_PROT_MASK),
  parameter  int                  BYPASS    = 1,
  localparam int                  AW        = addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [AW-1:0]            claim_addr,
  output logic                     claim_ok,
  input  logic [AW-1:0]            dbg_addr,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     wr_err
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [DATA_W-1:0] r_dbg_data;
  logic              r_wr_err;
  logic              w_wr_valid;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .prot_mask  (PROT_MASK),
    .claim_ok   (claim_ok),
    .wr_valid   (w_wr_valid),
    .busy_vec   (busy_vec)
  );

  // Register storage; protected registers are never written, so they keep
  // their reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Debug port samples the stored (pre-edge) value, so a write lands on
  // dbg_data one edge after it lands in storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= r_mem[dbg_addr];
    end
  end

  // One-cycle flag per dropped write; consecutive bad writes hold it high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en && PROT_MASK[wr_addr];
    end
  end

  assign dbg_data = r_dbg_data;
  assign wr_err   = r_wr_err;

  // Read ports: a hit on an accepted writeback forwards wr_data and reports
  // not-busy unless a same-cycle granted claim re-marks that register.
  // rd_data depends only on rd_addr, wr_* and storage, never on claim_en.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic          w_hit;

    assign w_addr = rd_addr[rd_addr_lsb(p, AW) +: AW];
    assign w_hit  = (BYPASS != 0) && w_wr_valid && (wr_addr == w_addr);

    assign rd_data[rd_data_lsb(p, DATA_W) +: DATA_W] =
      w_hit ? wr_data : r_mem[w_addr];
    assign rd_busy[p] =
      w_hit ? (claim_ok && (claim_addr == w_addr)) : busy_vec[w_addr];
  end

endmodule
